// File: rtl/alu_md_unit_pkg.sv
// Shared op codes and FSM states for the execute-stage ALU and its multiply/divide core.
package alu_md_unit_pkg;

  typedef enum logic [3:0] {
    ALU_ADDU = 4'd0,  ALU_SUBU = 4'd1,  ALU_AND  = 4'd2,  ALU_OR   = 4'd3,
    ALU_LUI  = 4'd4,  ALU_PASSB = 4'd5, ALU_XOR  = 4'd6,  ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,  ALU_SLTU = 4'd9,  ALU_SLL  = 4'd10, ALU_SRL  = 4'd11,
    ALU_SRA  = 4'd12, ALU_ADD  = 4'd13, ALU_SUB  = 4'd14, ALU_ZERO = 4'd15
  } alu_op_e;

  typedef enum logic [2:0] {
    MD_NONE = 3'd0, MD_MULT = 3'd1, MD_MULTU = 3'd2, MD_DIV = 3'd3,
    MD_DIVU = 3'd4, MD_MTHI = 3'd5, MD_MTLO  = 3'd6, MD_NONE7 = 3'd7
  } md_op_e;

  localparam logic [1:0] MDRD_ALU = 2'd0;
  localparam logic [1:0] MDRD_HI  = 2'd1;
  localparam logic [1:0] MDRD_LO  = 2'd2;

  typedef enum logic {MD_IDLE = 1'b0, MD_RUN = 1'b1} md_state_e;

  function automatic logic md_is_start(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_mul(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

endpackage

// File: rtl/alu_md_unit_md_core.sv
// Multiply/divide core: latches operands, counts down the op latency, then writes HI/LO.
module alu_md_unit_md_core
  import alu_md_unit_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       md_op,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  md_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   mag_a, mag_b, uq, ur, res_hi, res_lo;
  logic               sgn;

  // Divide works on magnitudes and fixes signs afterwards; MIN/-1 falls out as MIN, rem 0.
  always_comb begin
    prod   = '0;
    mag_a  = opa_q;
    mag_b  = opb_q;
    uq     = '0;
    ur     = '0;
    sgn    = (op_q == MD_DIV);
    res_hi = '0;
    res_lo = '0;
    if (md_is_mul(op_q)) begin
      if (op_q == MD_MULT)
        prod = {{WIDTH{opa_q[WIDTH-1]}}, opa_q} * {{WIDTH{opb_q[WIDTH-1]}}, opb_q};
      else
        prod = {{WIDTH{1'b0}}, opa_q} * {{WIDTH{1'b0}}, opb_q};
      {res_hi, res_lo} = prod;
    end else if (opb_q == '0) begin
      res_lo = '1;
      res_hi = opa_q;
    end else begin
      if (sgn && opa_q[WIDTH-1]) mag_a = -opa_q;
      if (sgn && opb_q[WIDTH-1]) mag_b = -opb_q;
      uq     = mag_a / mag_b;
      ur     = mag_a % mag_b;
      res_lo = (sgn && (opa_q[WIDTH-1] ^ opb_q[WIDTH-1])) ? -uq : uq;
      res_hi = (sgn && opa_q[WIDTH-1]) ? -ur : ur;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      MD_IDLE: begin
        if (md_is_start(md_op)) begin
          state_d = MD_RUN;
          op_d    = md_op;
          opa_d   = a;
          opb_d   = b;
          cnt_d   = md_is_mul(md_op) ? CW'(MUL_CYCLES) : CW'(DIV_CYCLES);
        end else if (md_op == MD_MTHI) begin
          hi_d = a;
        end else if (md_op == MD_MTLO) begin
          lo_d = a;
        end
      end
      MD_RUN: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = MD_IDLE;
          hi_d    = res_hi;
          lo_d    = res_lo;
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      op_q    <= MD_NONE;
      opa_q   <= '0;
      opb_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == MD_RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: rtl/alu_md_unit.sv
// Execute-stage ALU with iterative multiply/divide, HI/LO read and hazard stall.
// Optional feature: define ALU_OVERFLOW_EN for signed add/sub overflow on codes 13/14.
module alu_md_unit
  import alu_md_unit_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  input  logic [$clog2(WIDTH)-1:0] shamt,
  input  logic [3:0]               alu_ctr,
  input  logic [2:0]               md_op,
  input  logic [1:0]               md_rd,
  output logic [WIDTH-1:0]         result,
  output logic                     busy,
  output logic                     stall,
  output logic                     overflow
);

  logic [WIDTH-1:0] hi, lo, alu_y, sum, diff;

  alu_md_unit_md_core #(
    .WIDTH     (WIDTH),
    .MUL_CYCLES(MUL_CYCLES),
    .DIV_CYCLES(DIV_CYCLES)
  ) u_md_core (
    .clk  (clk),
    .reset(reset),
    .a    (a),
    .b    (b),
    .md_op(md_op),
    .busy (busy),
    .hi   (hi),
    .lo   (lo)
  );

  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    alu_y = '0;
    case (alu_ctr)
      ALU_ADDU, ALU_ADD: alu_y = sum;
      ALU_SUBU, ALU_SUB: alu_y = diff;
      ALU_AND:   alu_y = a & b;
      ALU_OR:    alu_y = a | b;
      ALU_LUI:   alu_y = b << 16;
      ALU_PASSB: alu_y = b;
      ALU_XOR:   alu_y = a ^ b;
      ALU_NOR:   alu_y = ~(a | b);
      ALU_SLT:   alu_y = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU:  alu_y = {{(WIDTH-1){1'b0}}, a < b};
      ALU_SLL:   alu_y = b << shamt;
      ALU_SRL:   alu_y = b >> shamt;
      ALU_SRA:   alu_y = $signed(b) >>> shamt;
      default:   alu_y = '0;
    endcase
  end

  always_comb begin
    case (md_rd)
      MDRD_HI: result = hi;
      MDRD_LO: result = lo;
      default: result = alu_y;
    endcase
  end

  // HI/LO reads and new MD ops must wait until the running op has written back.
  assign stall = busy & ((md_op != MD_NONE) | (md_rd == MDRD_HI) | (md_rd == MDRD_LO));

`ifdef ALU_OVERFLOW_EN
  always_comb begin
    overflow = 1'b0;
    if (alu_ctr == ALU_ADD)
      overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    else if (alu_ctr == ALU_SUB)
      overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
  end
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_alu_md_unit.sv
module tb_alu_md_unit;
  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  a, b, result;
  logic [4:0]    shamt;
  logic [3:0]    alu_ctr;
  logic [2:0]    md_op;
  logic [1:0]    md_rd;
  logic          busy, stall, overflow;

  alu_md_unit #(.WIDTH(W), .MUL_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .shamt(shamt), .alu_ctr(alu_ctr),
    .md_op(md_op), .md_rd(md_rd), .result(result), .busy(busy), .stall(stall),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic        busy;
    logic        stall;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   bcnt   = 0;

  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  int          m_left = 0;

  function automatic logic [31:0] alu_ref(input logic [31:0] x, input logic [31:0] y,
                                          input logic [4:0] sh, input logic [3:0] op);
    case (op)
      4'd0, 4'd13: return x + y;
      4'd1, 4'd14: return x - y;
      4'd2:  return x & y;
      4'd3:  return x | y;
      4'd4:  return y * 32'h1_0000;
      4'd5:  return y;
      4'd6:  return x ^ y;
      4'd7:  return ~(x | y);
      4'd8:  return (int'(x) < int'(y)) ? 32'd1 : 32'd0;
      4'd9:  return (longint'({32'b0, x}) < longint'({32'b0, y})) ? 32'd1 : 32'd0;
      4'd10: return y * (32'd1 << sh);
      4'd11: return y / (32'd1 << sh);
      4'd12: return 32'($signed(y) >>> sh);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ovf_ref(input logic [31:0] x, input logic [31:0] y, input logic [3:0] op);
`ifdef ALU_OVERFLOW_EN
    longint s;
    if (op == 4'd13)      s = longint'(int'(x)) + longint'(int'(y));
    else if (op == 4'd14) s = longint'(int'(x)) - longint'(int'(y));
    else return 1'b0;
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
`else
    return 1'b0;
`endif
  endfunction

  task automatic md_ref(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] h, output logic [31:0] l);
    logic [63:0] p;
    int q, r;
    if (op == 3'd1) begin
      p = 64'(longint'(int'(x)) * longint'(int'(y)));
      h = p[63:32]; l = p[31:0];
    end else if (op == 3'd2) begin
      p = {32'b0, x} * {32'b0, y};
      h = p[63:32]; l = p[31:0];
    end else if (y == 0) begin
      l = 32'hFFFF_FFFF; h = x;
    end else if (op == 3'd3 && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      l = 32'h8000_0000; h = 32'h0;
    end else if (op == 3'd3) begin
      q = int'(x) / int'(y);
      r = int'(x) % int'(y);
      l = q; h = r;
    end else begin
      l = x / y; h = x % y;
    end
  endtask

  task automatic cyc(input logic r, input logic [31:0] ia, input logic [31:0] ib,
                     input logic [4:0] sh, input logic [3:0] op, input logic [2:0] mo,
                     input logic [1:0] rd, input string tag);
    exp_t e;
    reset = r; a = ia; b = ib; shamt = sh; alu_ctr = op; md_op = mo; md_rd = rd;
    e.tag   = tag;
    e.busy  = (m_left > 0);
    e.stall = e.busy && (mo != 3'd0 || rd == 2'd1 || rd == 2'd2);
    e.res   = (rd == 2'd1) ? m_hi : (rd == 2'd2) ? m_lo : alu_ref(ia, ib, sh, op);
    e.ovf   = ovf_ref(ia, ib, op);
    sb.push_back(e);
    @(posedge clk);
    if (r) begin
      m_hi = '0; m_lo = '0; m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin m_hi = p_hi; m_lo = p_lo; end
    end else if (mo >= 3'd1 && mo <= 3'd4) begin
      md_ref(mo, ia, ib, p_hi, p_lo);
      m_left = (mo <= 3'd2) ? MC : DC;
    end else if (mo == 3'd5) begin
      m_hi = ia;
    end else if (mo == 3'd6) begin
      m_lo = ia;
    end
    #1;
  endtask

  task automatic idle(input int n, input logic [1:0] rd);
    for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 32'h0, 5'd0, 4'd0, 3'd0, rd, "idle");
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (result !== e.res || busy !== e.busy || stall !== e.stall || overflow !== e.ovf) begin
        errors++;
        $display("FAIL %s t=%0t: result %h want %h busy %b want %b stall %b want %b ovf %b want %b",
                 e.tag, $time, result, e.res, busy, e.busy, stall, e.stall, overflow, e.ovf);
      end
    end
  end

  always @(posedge clk) begin
    if (reset !== 1'b0 || busy !== 1'b1) begin
      bcnt = 0;
    end else begin
      bcnt++;
      if (bcnt > DC) begin
        errors++;
        $display("FAIL busy_timeout t=%0t: busy held %0d cycles, limit %0d", $time, bcnt, DC);
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL sim_timeout t=%0t: test did not finish", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h0;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1; a = '0; b = '0; shamt = '0; alu_ctr = '0; md_op = '0; md_rd = 2'd1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || stall !== 1'b0 || result !== 32'h0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state t=%0t: busy %b stall %b result %h ovf %b", $time, busy, stall,
               result, overflow);
    end
    cyc(1'b1, 32'h0, 32'h0, 5'd0, 4'd0, 3'd0, 2'd1, "rst_hi");
    cyc(1'b0, 32'h0, 32'h0, 5'd0, 4'd0, 3'd0, 2'd2, "rst_lo");

    cyc(1'b0, 32'h8000_0000, 32'h1, 5'd0, 4'd0, 3'd0, 2'd0, "addu");
    cyc(1'b0, 32'h8000_0000, 32'h1, 5'd0, 4'd8, 3'd0, 2'd0, "slt");
    cyc(1'b0, 32'h8000_0000, 32'h1, 5'd0, 4'd9, 3'd0, 2'd0, "sltu");
    cyc(1'b0, 32'h0, 32'h8000_0000, 5'd4, 4'd12, 3'd0, 2'd3, "sra");
    cyc(1'b0, 32'h0, 32'h0000_1234, 5'd0, 4'd4, 3'd0, 2'd0, "lui");
    cyc(1'b0, 32'h8000_0000, 32'h1, 5'd0, 4'd15, 3'd0, 2'd0, "code15");
    for (int op = 0; op < 16; op++)
      cyc(1'b0, 32'hF0F0_1234, 32'h8765_00FF, 5'd7, 4'(op), 3'd0, 2'd0, "alu_op");

    cyc(1'b0, -32'sd3, 32'd7, 5'd0, 4'd0, 3'd1, 2'd0, "mult");
    cyc(1'b0, 32'h0, 32'h0, 5'd0, 4'd0, 3'd0, 2'd0, "mult_b1");
    cyc(1'b0, 32'd9, 32'd9, 5'd0, 4'd0, 3'd1, 2'd1, "mult_again");
    cyc(1'b0, 32'd9, 32'd9, 5'd0, 4'd0, 3'd0, 2'd1, "mfhi_stall");
    cyc(1'b0, 32'd9, 32'd9, 5'd0, 4'd0, 3'd0, 2'd1, "mfhi_stall");
    cyc(1'b0, 32'd9, 32'd9, 5'd0, 4'd0, 3'd0, 2'd1, "mfhi_stall");
    cyc(1'b0, 32'd0, 32'd0, 5'd0, 4'd0, 3'd0, 2'd1, "mfhi");
    cyc(1'b0, 32'd0, 32'd0, 5'd0, 4'd0, 3'd0, 2'd2, "mflo");

    cyc(1'b0, 32'h8000_0000, 32'd2, 5'd0, 4'd0, 3'd2, 2'd0, "multu");
    idle(MC, 2'd1);
    cyc(1'b0, 32'h0, 32'h0, 5'd0, 4'd0, 3'd0, 2'd2, "multu_lo");

    cyc(1'b0, -32'sd7, 32'd2, 5'd0, 4'd0, 3'd3, 2'd0, "div");
    idle(DC, 2'd1);
    cyc(1'b0, 32'h0, 32'h0, 5'd0, 4'd0, 3'd0, 2'd2, "div_lo");
    cyc(1'b0, 32'd5, 32'd0, 5'd0, 4'd0, 3'd4, 2'd0, "divu0");
    idle(DC, 2'd2);
    cyc(1'b0, 32'h0, 32'h0, 5'd0, 4'd0, 3'd0, 2'd1, "divu0_hi");
    cyc(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 4'd0, 3'd3, 2'd0, "div_min");
    idle(DC, 2'd2);
    cyc(1'b0, 32'h0, 32'h0, 5'd0, 4'd0, 3'd0, 2'd1, "div_min_hi");
    cyc(1'b0, -32'sd9, 32'd0, 5'd0, 4'd0, 3'd3, 2'd0, "div0");
    idle(DC, 2'd1);
    cyc(1'b0, 32'h0, 32'h0, 5'd0, 4'd0, 3'd0, 2'd2, "div0_lo");

    cyc(1'b0, 32'd100, 32'd100, 5'd0, 4'd0, 3'd1, 2'd0, "mult_abort");
    idle(2, 2'd0);
    cyc(1'b1, 32'h0, 32'h0, 5'd0, 4'd0, 3'd1, 2'd0, "rst_run");
    idle(MC + 1, 2'd1);
    cyc(1'b0, 32'h0, 32'h0, 5'd0, 4'd0, 3'd0, 2'd2, "abort_lo");

    cyc(1'b0, 32'h0000_ABCD, 32'h0, 5'd0, 4'd0, 3'd5, 2'd0, "mthi");
    cyc(1'b0, 32'h0000_1357, 32'h0, 5'd0, 4'd0, 3'd6, 2'd1, "mtlo");
    cyc(1'b0, 32'h0, 32'h0, 5'd0, 4'd0, 3'd0, 2'd2, "mflo2");

    cyc(1'b0, 32'h7FFF_FFFF, 32'h1, 5'd0, 4'd13, 3'd0, 2'd0, "add_ovf");
    cyc(1'b0, 32'h7FFF_FFFF, 32'h1, 5'd0, 4'd0, 3'd0, 2'd0, "addu_noovf");
    cyc(1'b0, 32'h8000_0000, 32'h1, 5'd0, 4'd14, 3'd0, 2'd0, "sub_ovf");

    for (int i = 0; i < 600; i++) begin
      logic [2:0] mo;
      mo = ($urandom_range(0, 9) < 3) ? 3'($urandom_range(1, 7)) : 3'd0;
      cyc(($urandom_range(0, 99) == 0), pick(), pick(), 5'($urandom), 4'($urandom),
          mo, 2'($urandom), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
